rr_index_arbiter: RTL

RR_INDEX_ARBITER -- requirements
Module: rr_index_arbiter

---
 rtl/rr_index_arbiter_if.sv | 25 ++
 rtl/rr_index_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/rr_index_arbiter_if.sv
// rr_index_arbiter_if -- request/grant bundle between requesters and the
// round-robin index arbiter.
//   req         : per-requester request lines, bit i = requester i
//   done        : current grantee finished, releases the grant
//   grant_idx   : binary index of the current grantee
//   grant_valid : grant_idx is a live grant
//   timeout     : one-cycle pulse, grant force-released by the hold limit
// master = requester side, slave = arbiter side.
interface rr_index_arbiter_if;
  logic [7:0] req;
  logic       done;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  modport master (
    output req, done,
    input  grant_idx, grant_valid, timeout
  );

  modport slave (
    input  req, done,
    output grant_idx, grant_valid, timeout
  );
endinterface

// File: rtl/rr_index_arbiter.sv
// rr_index_arbiter -- 8-way round-robin arbiter producing a binary grant index.
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high
//   bus   : slave side of rr_index_arbiter_if (req/done in,
//           grant_idx/grant_valid/timeout out, all registered)
// A grant lasts until done, withdrawal of the grantee's request, or HOLD_MAX
// cycles, followed by one GAP cycle and one IDLE decision cycle.
module rr_index_arbiter #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic               clk,
  input  logic               reset,
  rr_index_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] hold_q, hold_d;
  logic [2:0] gidx_q, gidx_d;
  logic       gvalid_q, gvalid_d;
  logic       tmo_q, tmo_d;

  logic [2:0] pick;
  logic [2:0] cand;
  logic       found;
  logic       hit_limit;
  logic       still_req;

  // First set request bit in the order ptr, ptr+1, ..., ptr+7 (mod 8).
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!found && bus.req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gidx_d    = gidx_q;
    gvalid_d  = 1'b0;
    tmo_d     = 1'b0;
    hit_limit = (hold_q == HOLD_LAST);
    still_req = bus.req[gidx_q];
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d  = GRANT;
          gidx_d   = pick;
          gvalid_d = 1'b1;
          hold_d   = '0;
        end
      end
      GRANT: begin
        if (bus.done || !still_req || hit_limit) begin
          state_d = GAP;
          ptr_d   = gidx_q + 3'd1;
          hold_d  = '0;
          // Timeout only when the hold limit is the sole release cause.
          tmo_d   = hit_limit && !bus.done && still_req;
        end else begin
          gvalid_d = 1'b1;
          hold_d   = hold_q + 8'd1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      hold_q   <= '0;
      gidx_q   <= '0;
      gvalid_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
      gidx_q   <= gidx_d;
      gvalid_q <= gvalid_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.grant_idx   = gidx_q;
  assign bus.grant_valid = gvalid_q;
  assign bus.timeout     = tmo_q;

endmodule
